// File: rtl/mem_stage.sv
// MIPS memory stage: E->M pipeline register plus word-organised data memory with byte/half/word access.
// Loads are combinational from M state; stores commit on the edge that retires the instruction from M.
module mem_stage #(
  parameter int DM_WORDS  = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_M,
  input  logic [31:0] instr_E,
  input  logic [31:0] ALUout_E,
  input  logic [31:0] WriteData_E,
  input  logic [31:0] MDout_E,
  input  logic [4:0]  WRegAdd_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  Mem2Reg,
  output logic [31:0] instr_M,
  output logic [31:0] ALUout_M,
  output logic [31:0] MDout_M,
  output logic [4:0]  WRegAdd_M,
  output logic        RegWrite_M,
  output logic [1:0]  Mem2Reg_M,
  output logic [31:0] ReadData_M,
  output logic        AdE_M
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mdout_q, mdout_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwrite_q, regwrite_d;
  logic [1:0]  mem2reg_q, mem2reg_d;
  logic [31:0] mem_q [DM_WORDS];

  logic [ADDR_BITS-1:0] word_idx;
  logic [5:0]  op;
  logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
  logic        is_store, ade;
  logic [31:0] rd_word, byte_shift;
  logic [15:0] half_sel;
  logic [31:0] wr_word_d;
  logic        wr_en_d;
  logic [31:0] read_data;

  always_comb begin
    if (flush_M) begin
      instr_d    = '0;
      aluout_d   = '0;
      wdata_d    = '0;
      mdout_d    = '0;
      wreg_d     = '0;
      regwrite_d = 1'b0;
      mem2reg_d  = '0;
    end else begin
      instr_d    = instr_E;
      aluout_d   = ALUout_E;
      wdata_d    = WriteData_E;
      mdout_d    = MDout_E;
      wreg_d     = WRegAdd_E;
      regwrite_d = RegWrite_E;
      mem2reg_d  = Mem2Reg;
    end
  end

  assign op       = instr_q[31:26];
  assign is_lw    = (op == 6'b100011);
  assign is_lh    = (op == 6'b100001);
  assign is_lhu   = (op == 6'b100101);
  assign is_lb    = (op == 6'b100000);
  assign is_lbu   = (op == 6'b100100);
  assign is_sw    = (op == 6'b101011);
  assign is_sh    = (op == 6'b101001);
  assign is_sb    = (op == 6'b101000);
  assign is_store = is_sw | is_sh | is_sb;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_idx = aluout_q[ADDR_BITS+1:2];
  assign ade      = ((is_lw | is_sw) & (aluout_q[1:0] != 2'b00)) |
                    ((is_lh | is_lhu | is_sh) & aluout_q[0]);

  assign rd_word    = mem_q[word_idx];
  assign byte_shift = rd_word >> {aluout_q[1:0], 3'b000};
  assign half_sel   = aluout_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    wr_word_d = rd_word;
    wr_en_d   = is_store & ~ade;
    if (is_sw) begin
      wr_word_d = wdata_q;
    end else if (is_sh) begin
      if (aluout_q[1]) wr_word_d[31:16] = wdata_q[15:0];
      else             wr_word_d[15:0]  = wdata_q[15:0];
    end else if (is_sb) begin
      case (aluout_q[1:0])
        2'd0:    wr_word_d[7:0]   = wdata_q[7:0];
        2'd1:    wr_word_d[15:8]  = wdata_q[7:0];
        2'd2:    wr_word_d[23:16] = wdata_q[7:0];
        default: wr_word_d[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    if (!ade) begin
      if (is_lw)       read_data = rd_word;
      else if (is_lh)  read_data = {{16{half_sel[15]}}, half_sel};
      else if (is_lhu) read_data = {16'h0000, half_sel};
      else if (is_lb)  read_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      else if (is_lbu) read_data = {24'h000000, byte_shift[7:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= '0;
      aluout_q   <= '0;
      wdata_q    <= '0;
      mdout_q    <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      mem2reg_q  <= '0;
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      instr_q    <= instr_d;
      aluout_q   <= aluout_d;
      wdata_q    <= wdata_d;
      mdout_q    <= mdout_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      mem2reg_q  <= mem2reg_d;
      if (wr_en_d) mem_q[word_idx] <= wr_word_d;
    end
  end

  assign instr_M    = instr_q;
  assign ALUout_M   = aluout_q;
  assign MDout_M    = mdout_q;
  assign WRegAdd_M  = wreg_q;
  assign RegWrite_M = regwrite_q & ~ade;
  assign Mem2Reg_M  = mem2reg_q;
  assign ReadData_M = read_data;
  assign AdE_M      = ade;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan steps then random traffic against a byte-array memory model.
module tb_mem_stage;

  localparam logic [5:0] OP_LW = 6'h23, OP_LH = 6'h21, OP_LHU = 6'h25, OP_LB = 6'h20,
                         OP_LBU = 6'h24, OP_SW = 6'h2b, OP_SH = 6'h29, OP_SB = 6'h28,
                         OP_R = 6'h00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush_M = 1'b0;
  logic [31:0] instr_E = '0, ALUout_E = '0, WriteData_E = '0, MDout_E = '0;
  logic [4:0]  WRegAdd_E = '0;
  logic        RegWrite_E = 1'b0;
  logic [1:0]  Mem2Reg = '0;
  logic [31:0] instr_M, ALUout_M, MDout_M, ReadData_M;
  logic [4:0]  WRegAdd_M;
  logic        RegWrite_M, AdE_M;
  logic [1:0]  Mem2Reg_M;

  int checks = 0;
  int failures = 0;

  // reference state: M-stage contents and a 4 KB byte-addressed memory
  logic [31:0] m_instr, m_alu, m_wd, m_md;
  logic [4:0]  m_wreg;
  logic        m_rw;
  logic [1:0]  m_m2r;
  logic [7:0]  bmem [4096];

  mem_stage dut (
    .clk(clk), .reset(reset), .flush_M(flush_M), .instr_E(instr_E), .ALUout_E(ALUout_E),
    .WriteData_E(WriteData_E), .MDout_E(MDout_E), .WRegAdd_E(WRegAdd_E), .RegWrite_E(RegWrite_E),
    .Mem2Reg(Mem2Reg), .instr_M(instr_M), .ALUout_M(ALUout_M), .MDout_M(MDout_M),
    .WRegAdd_M(WRegAdd_M), .RegWrite_M(RegWrite_M), .Mem2Reg_M(Mem2Reg_M),
    .ReadData_M(ReadData_M), .AdE_M(AdE_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ade(input logic [31:0] ins, input logic [31:0] a);
    logic [5:0] o;
    o = ins[31:26];
    if ((o == OP_LW || o == OP_SW) && (a % 4 != 0)) return 1'b1;
    if ((o == OP_LH || o == OP_LHU || o == OP_SH) && (a % 2 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic is_ld(input logic [31:0] ins);
    logic [5:0] o;
    o = ins[31:26];
    return o == OP_LW || o == OP_LH || o == OP_LHU || o == OP_LB || o == OP_LBU;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] ins, input logic [31:0] a);
    int b;
    logic [5:0] o;
    logic [15:0] h;
    o = ins[31:26];
    b = int'(a % 4096);
    if (model_ade(ins, a)) return 32'h0;
    h = {bmem[(b + 1) % 4096], bmem[b]};
    case (o)
      OP_LW:  return {bmem[b + 3], bmem[b + 2], bmem[b + 1], bmem[b]};
      OP_LH:  return $unsigned(32'(signed'(h)));
      OP_LHU: return {16'h0, h};
      OP_LB:  return $unsigned(32'(signed'(bmem[b])));
      OP_LBU: return {24'h0, bmem[b]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_instr = '0; m_alu = '0; m_wd = '0; m_md = '0; m_wreg = '0; m_rw = 1'b0; m_m2r = '0;
    for (int i = 0; i < 4096; i++) bmem[i] = 8'h00;
  endtask

  task automatic model_edge();
    int b;
    b = int'(m_alu % 4096);
    if (!model_ade(m_instr, m_alu)) begin
      case (m_instr[31:26])
        OP_SW: for (int k = 0; k < 4; k++) bmem[b + k] = 8'(m_wd >> (8 * k));
        OP_SH: begin bmem[b] = m_wd[7:0]; bmem[b + 1] = m_wd[15:8]; end
        OP_SB: bmem[b] = m_wd[7:0];
        default: ;
      endcase
    end
    if (flush_M) begin
      m_instr = '0; m_alu = '0; m_wd = '0; m_md = '0; m_wreg = '0; m_rw = 1'b0; m_m2r = '0;
    end else begin
      m_instr = instr_E; m_alu = ALUout_E; m_wd = WriteData_E; m_md = MDout_E;
      m_wreg = WRegAdd_E; m_rw = RegWrite_E; m_m2r = Mem2Reg;
    end
  endtask

  task automatic check_all(input string tag);
    logic ade;
    ade = model_ade(m_instr, m_alu);
    chk({tag, ".instr"}, instr_M, m_instr);
    chk({tag, ".alu"}, ALUout_M, m_alu);
    chk({tag, ".md"}, MDout_M, m_md);
    chk({tag, ".wreg"}, 32'(WRegAdd_M), 32'(m_wreg));
    chk({tag, ".rw"}, 32'(RegWrite_M), 32'(m_rw & ~ade));
    chk({tag, ".m2r"}, 32'(Mem2Reg_M), 32'(m_m2r));
    chk({tag, ".ade"}, 32'(AdE_M), 32'(ade));
    chk({tag, ".rd"}, ReadData_M, model_read(m_instr, m_alu));
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic fl, input logic rw);
    logic [31:0] r;
    r = $urandom;
    instr_E = {op, r[25:0]};
    ALUout_E = a;
    WriteData_E = wd;
    MDout_E = $urandom;
    WRegAdd_E = r[30:26];
    RegWrite_E = rw;
    Mem2Reg = 2'($urandom_range(0, 3));
    flush_M = fl;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    logic [31:0] a;
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, OP_R};
    model_clear();
    #3 check_all("reset");
    #9 reset = 1'b1;
    #1 check_all("released");

    step("lw0", OP_LW, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("lw0_val", ReadData_M, 32'h0);
    step("sw10", OP_SW, 32'h10, 32'h12345678, 1'b0, 1'b0);
    step("lw10", OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
    chk("lw10_val", ReadData_M, 32'h12345678);
    step("lb13", OP_LB, 32'h13, 32'h0, 1'b0, 1'b1);
    chk("lb13_val", ReadData_M, 32'h00000012);
    step("lbu10", OP_LBU, 32'h10, 32'h0, 1'b0, 1'b1);
    chk("lbu10_val", ReadData_M, 32'h00000078);
    step("sb21", OP_SB, 32'h21, 32'hFFFFFF80, 1'b0, 1'b0);
    step("lb21", OP_LB, 32'h21, 32'h0, 1'b0, 1'b1);
    chk("lb21_val", ReadData_M, 32'hFFFFFF80);
    step("lbu21", OP_LBU, 32'h21, 32'h0, 1'b0, 1'b1);
    chk("lbu21_val", ReadData_M, 32'h00000080);
    step("lw20", OP_LW, 32'h20, 32'h0, 1'b0, 1'b1);
    chk("lw20_val", ReadData_M, 32'h00008000);
    step("sh32", OP_SH, 32'h32, 32'h1234BEEF, 1'b0, 1'b0);
    step("lh32", OP_LH, 32'h32, 32'h0, 1'b0, 1'b1);
    chk("lh32_val", ReadData_M, 32'hFFFFBEEF);
    step("lhu32", OP_LHU, 32'h32, 32'h0, 1'b0, 1'b1);
    chk("lhu32_val", ReadData_M, 32'h0000BEEF);
    step("lw30", OP_LW, 32'h30, 32'h0, 1'b0, 1'b1);
    chk("lw30_val", ReadData_M, 32'hBEEF0000);
    step("sw41", OP_SW, 32'h41, 32'hDEADDEAD, 1'b0, 1'b0);
    chk("sw41_ade", 32'(AdE_M), 32'h1);
    step("lh43", OP_LH, 32'h43, 32'h0, 1'b0, 1'b1);
    chk("lh43_ade", 32'(AdE_M), 32'h1);
    chk("lh43_rw", 32'(RegWrite_M), 32'h0);
    chk("lh43_rd", ReadData_M, 32'h0);
    step("lw40", OP_LW, 32'h40, 32'h0, 1'b0, 1'b1);
    chk("lw40_val", ReadData_M, 32'h0);
    step("sw50", OP_SW, 32'h50, 32'hCAFEF00D, 1'b0, 1'b0);
    step("lw50", OP_LW, 32'h50, 32'h0, 1'b0, 1'b1);
    chk("lw50_val", ReadData_M, 32'hCAFEF00D);
    step("flush", OP_SW, 32'h50, 32'h11111111, 1'b1, 1'b0);
    chk("flush_instr", instr_M, 32'h0);
    step("lw50b", OP_LW, 32'h50, 32'h0, 1'b0, 1'b1);
    chk("lw50b_val", ReadData_M, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0, 12'($urandom_range(0, 63))};
      step("rand", op, a, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    step("sw60", OP_SW, 32'h60, 32'hA5A5A5A5, 1'b0, 1'b0);
    instr_E = {OP_LW, 26'h0};
    ALUout_E = 32'h60;
    #2 reset = 1'b0;
    model_clear();
    #1 check_all("midrst");
    flush_M = 1'b1;
    instr_E = {OP_SW, 26'h0};
    @(posedge clk);
    #1 check_all("rst_hold");
    #2 reset = 1'b1;
    flush_M = 1'b0;
    step("lw60", OP_LW, 32'h60, 32'h0, 1'b0, 1'b1);
    chk("lw60_val", ReadData_M, 32'h0);
    step("lw10r", OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
    chk("lw10r_val", ReadData_M, 32'h0);
    step("lw50r", OP_LW, 32'h50, 32'h0, 1'b0, 1'b1);
    chk("lw50r_val", ReadData_M, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
